// File: rtl/systolic_drain.sv
// systolic_drain: read-out end of the PE array.
// Collects skewed per-column results from the bottom PE row into one FIFO per
// column, re-aligns them into whole rows and hands each row downstream over a
// valid/ready handshake. Raises array_stall early enough to absorb the
// in-flight skew when any column buffer nears full.
module systolic_drain #(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int ROW_W  = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [ROW_W-1:0]    num_rows,
  input  logic [N-1:0]        col_valid,
  input  logic [N*DATA_W-1:0] col_data,
  output logic                array_stall,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*DATA_W-1:0] out_data,
  output logic                busy,
  output logic                done,
  output logic                overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STALL_LVL = CNT_W'(DEPTH - N);
  localparam logic [ROW_W-1:0] ROW_ZERO  = {ROW_W{1'b0}};
  localparam logic [ROW_W-1:0] ROW_ONE   = {{(ROW_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ROW_W-1:0]    target_r;
  logic [ROW_W-1:0]    rows_out_r;
  logic                overflow_r;

  logic [DATA_W-1:0]   mem_r   [N][DEPTH];
  logic [PTR_W-1:0]    wptr_r  [N];
  logic [PTR_W-1:0]    rptr_r  [N];
  logic [CNT_W-1:0]    count_r [N];

  logic [N-1:0]        nonempty_s;
  logic [N-1:0]        near_full_s;
  logic [N-1:0]        push_ok_s;
  logic [N-1:0]        drop_s;
  logic [N*DATA_W-1:0] head_s;
  logic                out_valid_s;
  logic                pop_s;
  logic                start_acc_s;
  logic                last_row_s;

  // start is only honoured while idle; a row moves when both sides agree
  assign start_acc_s = start && (state_r == IDLE);
  assign out_valid_s = (state_r == DRAIN) && (&nonempty_s);
  assign pop_s       = out_valid_s && out_ready;
  assign last_row_s  = pop_s && ((rows_out_r + ROW_ONE) == target_r);

  assign out_valid   = out_valid_s;
  assign out_data    = head_s;
  assign array_stall = |near_full_s;
  assign busy        = (state_r != IDLE);
  assign done        = (state_r == DONE);
  assign overflow    = overflow_r;

  // Per-column occupancy flags and head entries, all from registered state
  always_comb begin
    nonempty_s  = {N{1'b0}};
    near_full_s = {N{1'b0}};
    head_s      = {(N*DATA_W){1'b0}};
    for (int c = 0; c < N; c++) begin
      nonempty_s[c]                = (count_r[c] != CNT_ZERO);
      near_full_s[c]               = (count_r[c] >= STALL_LVL);
      head_s[c*DATA_W +: DATA_W]   = mem_r[c][rptr_r[c]];
    end
  end

  // Push acceptance: only while draining, and a full column needs a same-cycle pop
  always_comb begin
    push_ok_s = {N{1'b0}};
    drop_s    = {N{1'b0}};
    for (int c = 0; c < N; c++) begin
      if (col_valid[c] && (state_r == DRAIN) && ((count_r[c] != FULL_LVL) || pop_s)) begin
        push_ok_s[c] = 1'b1;
      end else begin
        push_ok_s[c] = 1'b0;
      end
      drop_s[c] = col_valid[c] && !push_ok_s[c];
    end
  end

  // Next-state logic for the drain sequencer
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (num_rows != ROW_ZERO) begin
            state_nxt_s = DRAIN;
          end else begin
            state_nxt_s = DONE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRAIN: begin
        if (last_row_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Row target, rows-delivered counter and sticky overflow flag
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      target_r   <= ROW_ZERO;
      rows_out_r <= ROW_ZERO;
      overflow_r <= 1'b0;
    end else if (start_acc_s) begin
      target_r   <= num_rows;
      rows_out_r <= ROW_ZERO;
      overflow_r <= 1'b0;
    end else begin
      if (pop_s) begin
        rows_out_r <= rows_out_r + ROW_ONE;
      end
      if (|drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Column FIFOs: storage, pointers and counts; a new start flushes leftovers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int c = 0; c < N; c++) begin
        wptr_r[c]  <= PTR_ZERO;
        rptr_r[c]  <= PTR_ZERO;
        count_r[c] <= CNT_ZERO;
        for (int d = 0; d < DEPTH; d++) begin
          mem_r[c][d] <= {DATA_W{1'b0}};
        end
      end
    end else if (start_acc_s) begin
      for (int c = 0; c < N; c++) begin
        wptr_r[c]  <= PTR_ZERO;
        rptr_r[c]  <= PTR_ZERO;
        count_r[c] <= CNT_ZERO;
      end
    end else begin
      for (int c = 0; c < N; c++) begin
        if (push_ok_s[c]) begin
          mem_r[c][wptr_r[c]] <= col_data[c*DATA_W +: DATA_W];
          wptr_r[c]           <= wptr_r[c] + PTR_ONE;
        end
        if (pop_s) begin
          rptr_r[c] <= rptr_r[c] + PTR_ONE;
        end
        case ({push_ok_s[c], pop_s})
          2'b10:   count_r[c] <= count_r[c] + CNT_ONE;
          2'b01:   count_r[c] <= count_r[c] - CNT_ONE;
          default: count_r[c] <= count_r[c];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain: a vector table for the basic drain and
// zero-row cases, then hand-written sequences for back-pressure, overflow,
// full-with-pop, and reset mid-drain.
module tb_systolic_drain;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic [7:0]  num_rows;
  logic [3:0]  col_valid;
  logic [63:0] col_data;
  logic        array_stall;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;
  logic        done;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  systolic_drain #(.N(4), .DATA_W(16), .DEPTH(8), .ROW_W(8)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .num_rows(num_rows),
    .col_valid(col_valid), .col_data(col_data), .array_stall(array_stall),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .overflow(overflow)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [7:0]  num_rows;
    logic [3:0]  col_valid;
    logic [63:0] col_data;
    logic        out_ready;
    logic        e_valid;
    logic [63:0] e_data;
    logic        e_stall;
    logic        e_busy;
    logic        e_done;
    logic        e_ovf;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [63:0] row(input logic [15:0] a0, input logic [15:0] a1,
                                     input logic [15:0] a2, input logic [15:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic vec_t mk(input logic st, input logic [7:0] nr, input logic [3:0] cv,
                              input logic [63:0] cd, input logic rdy, input logic ev,
                              input logic [63:0] ed, input logic es, input logic eb,
                              input logic edn, input logic eo);
    vec_t v;
    v.start = st; v.num_rows = nr; v.col_valid = cv; v.col_data = cd; v.out_ready = rdy;
    v.e_valid = ev; v.e_data = ed; v.e_stall = es; v.e_busy = eb; v.e_done = edn; v.e_ovf = eo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [7:0] nr, input logic [3:0] cv,
                       input logic [63:0] cd, input logic rdy);
    start = st; num_rows = nr; col_valid = cv; col_data = cd; out_ready = rdy;
  endtask

  initial begin
    n_rst = 1'b0;
    drive(1'b0, 8'd0, 4'b0000, 64'h0, 1'b0);

    // Table: drain two skewed rows, then a zero-row start and a push while idle
    vecs[0]  = mk(1'b1, 8'd2, 4'b0000, 64'h0,                   1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(1'b0, 8'd0, 4'b0001, 64'h0000_0000_0000_0000, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 8'd0, 4'b0011, 64'h0000_0000_0010_0001, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 8'd0, 4'b0110, 64'h0000_0020_0011_0000, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 8'd0, 4'b1100, 64'h0030_0021_0000_0000, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[5]  = mk(1'b0, 8'd0, 4'b1000, 64'h0031_0000_0000_0000, 1'b1, 1'b1, 64'h0030_0020_0010_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[6]  = mk(1'b0, 8'd0, 4'b0000, 64'h0,                   1'b1, 1'b1, 64'h0031_0021_0011_0001, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[7]  = mk(1'b0, 8'd0, 4'b0000, 64'h0,                   1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    vecs[8]  = mk(1'b0, 8'd0, 4'b0000, 64'h0,                   1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[9]  = mk(1'b1, 8'd0, 4'b0000, 64'h0,                   1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[10] = mk(1'b0, 8'd0, 4'b0000, 64'h0,                   1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    vecs[11] = mk(1'b0, 8'd0, 4'b1111, 64'h0004_0003_0002_0001, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[12] = mk(1'b0, 8'd0, 4'b0000, 64'h0,                   1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset state
    tick();
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_data", out_data, 64'h0);
    chk("rst_stall", 64'(array_stall), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_ovf", 64'(overflow), 64'h0);
    tick();
    n_rst = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].start, vecs[i].num_rows, vecs[i].col_valid, vecs[i].col_data, vecs[i].out_ready);
      #2;
      chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'(vecs[i].e_valid));
      if (vecs[i].e_valid) chk($sformatf("v%0d_data", i), out_data, vecs[i].e_data);
      chk($sformatf("v%0d_stall", i), 64'(array_stall), 64'(vecs[i].e_stall));
      chk($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
      chk($sformatf("v%0d_done", i), 64'(done), 64'(vecs[i].e_done));
      chk($sformatf("v%0d_ovf", i), 64'(overflow), 64'(vecs[i].e_ovf));
      tick();
    end
    drive(1'b0, 8'd0, 4'b0000, 64'h0, 1'b0);

    // Back-pressure: five skewed rows with ready low, stall at count 4
    drive(1'b1, 8'd5, 4'b0000, 64'h0, 1'b0);
    tick();
    start = 1'b0;
    for (int t = 0; t < 8; t++) begin
      col_valid = 4'b0000;
      col_data  = 64'h0;
      for (int c = 0; c < 4; c++) begin
        if ((t - c) >= 0 && (t - c) < 5) begin
          col_valid[c] = 1'b1;
          col_data[c*16 +: 16] = 16'(16 * c + (t - c));
        end
      end
      #2;
      chk($sformatf("bp_stall_t%0d", t), 64'(array_stall), 64'(t >= 4));
      tick();
    end
    col_valid = 4'b0000;
    for (int h = 0; h < 3; h++) begin
      #2;
      chk("bp_hold_valid", 64'(out_valid), 64'h1);
      chk("bp_hold_data", out_data, row(16'h00, 16'h10, 16'h20, 16'h30));
      tick();
    end
    out_ready = 1'b1;
    for (int r = 0; r < 5; r++) begin
      #2;
      chk($sformatf("bp_row%0d_valid", r), 64'(out_valid), 64'h1);
      chk($sformatf("bp_row%0d_data", r), out_data,
          row(16'(r), 16'(16'h10 + r), 16'(16'h20 + r), 16'(16'h30 + r)));
      tick();
    end
    #2;
    chk("bp_done", 64'(done), 64'h1);
    chk("bp_ovf", 64'(overflow), 64'h0);
    out_ready = 1'b0;
    tick();

    // Overflow: nine pushes into column 0 with no pops
    drive(1'b1, 8'd1, 4'b0000, 64'h0, 1'b0);
    tick();
    start = 1'b0;
    #2;
    chk("ov_cleared_by_start", 64'(overflow), 64'h0);
    for (int i = 0; i < 9; i++) begin
      col_valid = 4'b0001;
      col_data  = row(16'(16'h100 + i), 16'h0, 16'h0, 16'h0);
      #2;
      if (i == 8) chk("ov_before_9th", 64'(overflow), 64'h0);
      tick();
    end
    col_valid = 4'b0000;
    #2;
    chk("ov_after_9th", 64'(overflow), 64'h1);
    chk("ov_stall", 64'(array_stall), 64'h1);
    drive(1'b0, 8'd0, 4'b1110, row(16'h0, 16'hA1, 16'hA2, 16'hA3), 1'b1);
    tick();
    col_valid = 4'b0000;
    #2;
    chk("ov_row_valid", 64'(out_valid), 64'h1);
    chk("ov_row_data", out_data, row(16'h100, 16'hA1, 16'hA2, 16'hA3));
    tick();
    #2;
    chk("ov_done", 64'(done), 64'h1);
    chk("ov_sticky", 64'(overflow), 64'h1);
    out_ready = 1'b0;
    tick();

    // Full column 0 with pop and push in the same cycle
    drive(1'b1, 8'd9, 4'b0000, 64'h0, 1'b0);
    tick();
    start = 1'b0;
    #2;
    chk("fp_ovf_cleared", 64'(overflow), 64'h0);
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        col_valid = 4'b1111;
        col_data  = row(16'h0A00, 16'h0100, 16'h0200, 16'h0300);
      end else begin
        col_valid = 4'b0001;
        col_data  = row(16'(16'h0A00 + i), 16'h0, 16'h0, 16'h0);
      end
      tick();
    end
    #2;
    chk("fp_stall", 64'(array_stall), 64'h1);
    chk("fp_ovf_full", 64'(overflow), 64'h0);
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      col_valid = (k < 8) ? 4'b1110 : 4'b0000;
      col_data  = row(16'h0, 16'(16'h0100 + k + 1), 16'(16'h0200 + k + 1), 16'(16'h0300 + k + 1));
      if (k == 0) begin
        col_valid[0] = 1'b1;
        col_data[15:0] = 16'h0AFF;
      end
      #2;
      chk($sformatf("fp_row%0d_valid", k), 64'(out_valid), 64'h1);
      chk($sformatf("fp_row%0d_data", k), out_data,
          row((k < 8) ? 16'(16'h0A00 + k) : 16'h0AFF,
              16'(16'h0100 + k), 16'(16'h0200 + k), 16'(16'h0300 + k)));
      tick();
    end
    col_valid = 4'b0000;
    #2;
    chk("fp_done", 64'(done), 64'h1);
    chk("fp_ovf_end", 64'(overflow), 64'h0);
    out_ready = 1'b0;
    tick();

    // Reset in the middle of a three-row drain
    drive(1'b1, 8'd3, 4'b0000, 64'h0, 1'b0);
    tick();
    start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      col_valid = 4'b1111;
      col_data  = row(16'(16'h0B00 + r), 16'(16'h0B10 + r), 16'(16'h0B20 + r), 16'(16'h0B30 + r));
      tick();
    end
    col_valid = 4'b0000;
    out_ready = 1'b1;
    #2;
    chk("rm_row0_data", out_data, row(16'h0B00, 16'h0B10, 16'h0B20, 16'h0B30));
    tick();
    out_ready = 1'b0;
    n_rst = 1'b0;
    #1;
    chk("rm_valid", 64'(out_valid), 64'h0);
    chk("rm_data", out_data, 64'h0);
    chk("rm_stall", 64'(array_stall), 64'h0);
    chk("rm_busy", 64'(busy), 64'h0);
    chk("rm_done", 64'(done), 64'h0);
    chk("rm_ovf", 64'(overflow), 64'h0);
    tick();
    n_rst = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #2;
      chk("rm_no_done", 64'(done), 64'h0);
      chk("rm_idle", 64'(busy), 64'h0);
      tick();
    end
    drive(1'b1, 8'd1, 4'b0000, 64'h0, 1'b0);
    tick();
    start = 1'b0;
    #2;
    chk("rm_restart_empty", 64'(out_valid), 64'h0);
    drive(1'b0, 8'd0, 4'b1111, row(16'h00C0, 16'h00C1, 16'h00C2, 16'h00C3), 1'b1);
    tick();
    col_valid = 4'b0000;
    #2;
    chk("rm_restart_valid", 64'(out_valid), 64'h1);
    chk("rm_restart_data", out_data, row(16'h00C0, 16'h00C1, 16'h00C2, 16'h00C3));
    tick();
    #2;
    chk("rm_restart_done", 64'(done), 64'h1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
